// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ALU issue stage: opcode and state
//                enums, instruction field positions, the instruction struct
//                and an immediate-extraction helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Opcodes carried in instr[15:12]; 7..14 are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_XOR  = 4'd5,
        OP_LI   = 4'd6,
        OP_HALT = 4'd15
    } op_e;

    // Instruction field positions
    localparam int unsigned C_OP_MSB  = 15;
    localparam int unsigned C_OP_LSB  = 12;
    localparam int unsigned C_RD_MSB  = 11;
    localparam int unsigned C_RD_LSB  = 9;
    localparam int unsigned C_RS1_MSB = 8;
    localparam int unsigned C_RS1_LSB = 6;
    localparam int unsigned C_RS2_MSB = 5;
    localparam int unsigned C_RS2_LSB = 3;
    localparam int unsigned C_IMM_MSB = 7;
    localparam int unsigned C_IMM_LSB = 0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // The 8-bit LI immediate overlaps rs1[1:0], rs2 and the low pad field,
    // so it is rebuilt from those fields rather than stored separately.
    typedef struct packed {
        logic [3:0] op;      // [15:12]
        logic [2:0] rd;      // [11:9]
        logic [2:0] rs1;     // [8:6]
        logic [2:0] rs2;     // [5:3]
        logic [2:0] imm_lo;  // [2:0]
    } instr_t;

    function automatic logic [7:0] instr_imm(input instr_t i);
        return {i.rs1[1:0], i.rs2, i.imm_lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : 8 x DATA_W register file, r0 hardwired to zero.
//                Ports: clk, rst_n (async active-low); two combinational
//                read ports (rd_addr_a/b -> rd_data_a/b); a debug read port
//                (dbg_addr -> dbg_data); one write port (wr_en, wr_addr,
//                wr_data) committed on the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] w_regs [8];

    // r0 has no storage; writes addressed to it simply fall away.
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < 8; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;

        always_comb begin
            reg_d = reg_q;
            if (wr_en && (wr_addr == 3'(gi))) begin
                reg_d = wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign w_regs[gi] = reg_q;
    end

    // Reads see committed state only; a same-cycle write is not bypassed.
    assign rd_data_a = w_regs[rd_addr_a];
    assign rd_data_b = w_regs[rd_addr_b];
    assign dbg_data  = w_regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Decode / operand-fetch / writeback stage in front of an
//                8-bit combinational ALU. One EX register drives the ALU;
//                its result is written back on the following edge.
//                Ports: clk, rst_n (async active-low); instr_valid/
//                instr_ready/instr handshake; resume (HALT -> RUN);
//                alu_a/alu_b/alu_op to the ALU, alu_result back; ex_valid,
//                halted status; dbg_addr/dbg_data register peek;
//                illegal_cnt (saturating), retire_cnt (wrapping).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              resume,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              ex_valid,
    output logic              halted,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [7:0]        illegal_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    state_e            state_q,       state_d;
    logic              ex_valid_q,    ex_valid_d;
    logic [2:0]        ex_rd_q,       ex_rd_d;
    logic [DATA_W-1:0] alu_a_q,       alu_a_d;
    logic [DATA_W-1:0] alu_b_q,       alu_b_d;
    logic [3:0]        alu_op_q,      alu_op_d;
    logic [7:0]        illegal_cnt_q, illegal_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q,  retire_cnt_d;

    instr_t            w_instr;
    logic              w_accept;
    logic              w_is_alu;
    logic              w_is_li;
    logic              w_is_halt;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    assign w_instr   = instr_t'(instr);
    assign w_is_alu  = (w_instr.op <= 4'd5);
    assign w_is_li   = (w_instr.op == OP_LI);
    assign w_is_halt = (w_instr.op == OP_HALT);
    assign w_accept  = instr_valid && (state_q == ST_RUN);

    // Ready drops while reset is held even though the state already reads RUN.
    assign instr_ready = (state_q == ST_RUN) && rst_n;

    alu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (w_instr.rs1),
        .rd_data_a (w_rf_a),
        .rd_addr_b (w_instr.rs2),
        .rd_data_b (w_rf_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (ex_valid_q),
        .wr_addr   (ex_rd_q),
        .wr_data   (alu_result)
    );

    // Operand select: r0 wins over forwarding, forwarding over the file.
    // The EX instruction has not committed yet, so its result is taken
    // straight from the ALU.
    always_comb begin
        w_rs1_val = w_rf_a;
        if (w_instr.rs1 == 3'd0) begin
            w_rs1_val = '0;
        end else if (ex_valid_q && (ex_rd_q == w_instr.rs1)) begin
            w_rs1_val = alu_result;
        end

        w_rs2_val = w_rf_b;
        if (w_instr.rs2 == 3'd0) begin
            w_rs2_val = '0;
        end else if (ex_valid_q && (ex_rd_q == w_instr.rs2)) begin
            w_rs2_val = alu_result;
        end
    end

    always_comb begin
        state_d       = state_q;
        ex_valid_d    = 1'b0;
        ex_rd_d       = ex_rd_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        illegal_cnt_d = illegal_cnt_q;
        retire_cnt_d  = retire_cnt_q;

        // Whatever sits in EX now is written back at this edge.
        if (ex_valid_q) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (w_accept) begin
                    if (w_is_alu) begin
                        ex_valid_d = 1'b1;
                        ex_rd_d    = w_instr.rd;
                        alu_a_d    = w_rs1_val;
                        alu_b_d    = w_rs2_val;
                        alu_op_d   = w_instr.op;
                    end else if (w_is_li) begin
                        // The immediate passes through the ALU as imm + 0.
                        ex_valid_d = 1'b1;
                        ex_rd_d    = w_instr.rd;
                        alu_a_d    = DATA_W'(instr_imm(w_instr));
                        alu_b_d    = '0;
                        alu_op_d   = OP_ADD;
                    end else if (w_is_halt) begin
                        state_d = ST_HALT;
                    end else if (illegal_cnt_q != 8'hFF) begin
                        illegal_cnt_d = illegal_cnt_q + 8'd1;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            illegal_cnt_q <= '0;
            retire_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_rd_q       <= ex_rd_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            illegal_cnt_q <= illegal_cnt_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign ex_valid    = ex_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign illegal_cnt = illegal_cnt_q;
    assign retire_cnt  = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage with a behavioural
//                8-bit ALU attached. Directed vector table plus hand-written
//                sequences for illegal ops, HALT/resume and mid-flight reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        resume;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic        ex_valid;
    logic        halted;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [7:0]  illegal_cnt;
    logic [15:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    alu_issue_stage #(
        .DATA_W (8),
        .CNT_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .resume      (resume),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .ex_valid    (ex_valid),
        .halted      (halted),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .illegal_cnt (illegal_cnt),
        .retire_cnt  (retire_cnt)
    );

    // Downstream ALU
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
            4'd5:    alu_result = alu_a ^ alu_b;
            default: alu_result = 8'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        exp_valid;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [3:0]  exp_op;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] exp_rf [8];

    task automatic check_rf(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), 32'(dbg_data), 32'(exp_rf[r]));
        end
    endtask

    initial begin
        // instr, valid, a, b, op  (operands observed while in EX)
        vecs[0] = '{16'h6205, 1'b1, 8'h05, 8'h00, 4'd0};  // LI  r1,0x05
        vecs[1] = '{16'h6403, 1'b1, 8'h03, 8'h00, 4'd0};  // LI  r2,0x03
        vecs[2] = '{16'h0650, 1'b1, 8'h05, 8'h03, 4'd0};  // ADD r3,r1,r2 (r2 fwd)
        vecs[3] = '{16'h1888, 1'b1, 8'h03, 8'h05, 4'd1};  // SUB r4,r2,r1
        vecs[4] = '{16'h2F20, 1'b1, 8'hFE, 8'hFE, 4'd2};  // AND r7,r4,r4 (both fwd)
        vecs[5] = '{16'h4A88, 1'b1, 8'h03, 8'h05, 4'd4};  // SLT r5,r2,r1
        vecs[6] = '{16'h5C48, 1'b1, 8'h05, 8'h05, 4'd5};  // XOR r6,r1,r1
        vecs[7] = '{16'h60AA, 1'b1, 8'hAA, 8'h00, 4'd0};  // LI  r0,0xAA
        vecs[8] = '{16'h0E00, 1'b1, 8'h00, 8'h00, 4'd0};  // ADD r7,r0,r0 (no fwd)

        exp_rf[0] = 8'h00; exp_rf[1] = 8'h05; exp_rf[2] = 8'h03; exp_rf[3] = 8'h08;
        exp_rf[4] = 8'hFE; exp_rf[5] = 8'h01; exp_rf[6] = 8'h00; exp_rf[7] = 8'h00;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        resume      = 1'b0;
        dbg_addr    = 3'd0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_ready_low", 32'(instr_ready), 32'd0);
        check("rst_ex_valid",  32'(ex_valid),    32'd0);
        check("rst_alu_a",     32'(alu_a),       32'd0);
        check("rst_alu_b",     32'(alu_b),       32'd0);
        check("rst_alu_op",    32'(alu_op),      32'd0);
        check("rst_halted",    32'(halted),      32'd0);
        check("rst_illegal",   32'(illegal_cnt), 32'd0);
        check("rst_retire",    32'(retire_cnt),  32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(instr_ready), 32'd1);

        // ---------------- vector table, back-to-back ----------------
        for (int i = 0; i < 9; i++) begin
            instr_valid = 1'b1;
            instr       = vecs[i].instr;
            tick();
            check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_alu_a", i),    32'(alu_a),    32'(vecs[i].exp_a));
            check($sformatf("v%0d_alu_b", i),    32'(alu_b),    32'(vecs[i].exp_b));
            check($sformatf("v%0d_alu_op", i),   32'(alu_op),   32'(vecs[i].exp_op));
            check($sformatf("v%0d_retire", i),   32'(retire_cnt), 32'(i));
            if (i == 3) begin
                // SUB r4 is in EX: debug read still shows the old value.
                dbg_addr = 3'd4;
                #1;
                check("dbg_prewrite_r4", 32'(dbg_data), 32'h00);
            end
        end
        instr_valid = 1'b0;
        tick();
        check("table_ex_idle", 32'(ex_valid),   32'd0);
        check("table_retire",  32'(retire_cnt), 32'd9);
        check_rf("table");

        // ---------------- illegal ops, saturation ----------------
        for (int i = 0; i < 300; i++) begin
            instr_valid = 1'b1;
            instr       = {4'(7 + (i % 8)), 12'hFFF};
            tick();
            check($sformatf("ill%0d_ex_valid", i), 32'(ex_valid), 32'd0);
            if (i == 253) check("ill_cnt_254", 32'(illegal_cnt), 32'd254);
        end
        instr_valid = 1'b0;
        tick();
        check("ill_cnt_sat",  32'(illegal_cnt), 32'd255);
        check("ill_retire",   32'(retire_cnt),  32'd9);
        check("ill_halted",   32'(halted),      32'd0);
        check_rf("ill");

        // ---------------- HALT / resume ----------------
        instr_valid = 1'b1;
        instr       = 16'h6211;                 // LI r1,0x11
        tick();
        check("halt_li_valid", 32'(ex_valid), 32'd1);
        check("halt_li_a",     32'(alu_a),    32'h11);
        instr = 16'hF000;                       // HALT
        tick();
        check("halt_halted",   32'(halted),      32'd1);
        check("halt_ready",    32'(instr_ready), 32'd0);
        check("halt_ex_valid", 32'(ex_valid),    32'd0);
        check("halt_retire",   32'(retire_cnt),  32'd10);
        dbg_addr = 3'd1;
        #1;
        check("halt_r1", 32'(dbg_data), 32'h11);
        instr = 16'h6499;                       // LI r2,0x99 held, must not issue
        repeat (3) tick();
        check("halt_hold_ready",  32'(instr_ready), 32'd0);
        check("halt_hold_halted", 32'(halted),      32'd1);
        check("halt_hold_ex",     32'(ex_valid),    32'd0);
        check("halt_hold_retire", 32'(retire_cnt),  32'd10);
        resume = 1'b1;
        tick();
        resume      = 1'b0;
        instr_valid = 1'b0;
        check("resume_halted", 32'(halted),      32'd0);
        check("resume_ready",  32'(instr_ready), 32'd1);
        check("resume_ex",     32'(ex_valid),    32'd0);
        tick();
        dbg_addr = 3'd2;
        #1;
        check("resume_r2_unchanged", 32'(dbg_data),   32'h03);
        check("resume_retire",       32'(retire_cnt), 32'd10);
        resume = 1'b1;                          // ignored in RUN
        tick();
        resume = 1'b0;
        check("resume_in_run", 32'(halted), 32'd0);

        // ---------------- reset with EX in flight ----------------
        instr_valid = 1'b1;
        instr       = 16'h6477;                 // LI r2,0x77
        tick();
        check("rst2_ex_valid_before", 32'(ex_valid), 32'd1);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("rst2_ex_valid", 32'(ex_valid),    32'd0);
        check("rst2_illegal",  32'(illegal_cnt), 32'd0);
        check("rst2_retire",   32'(retire_cnt),  32'd0);
        check("rst2_halted",   32'(halted),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst2_ready",        32'(instr_ready), 32'd1);
        check("rst2_retire_after", 32'(retire_cnt),  32'd0);
        for (int r = 0; r < 8; r++) exp_rf[r] = 8'h00;
        check_rf("rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-fetch/writeback stage that sits directly upstream of the 8-bit combinational ALU (ops 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor).
- Accepts 16-bit instructions over a valid/ready handshake and reads an 8x8 register file.
- Drives the ALU operands and op from a single EX pipeline register, then writes the ALU result back one edge later.
- Provides forwarding, a HALT state, and counters and a debug read port for verification.

Parameters:
DATA_W, 8, operand/result width (must match ALU)
CNT_W, 16, width of retire counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  stage can accept; low only in HALT or during reset
instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LI only)
resume  in  1  single-cycle pulse; HALT -> RUN
alu_a  out  DATA_W  ALU reg_1
alu_b  out  DATA_W  ALU reg_2
alu_op  out  4  ALU op
alu_result  in  DATA_W  ALU out (combinational, same cycle)
ex_valid  out  1  EX register holds a writing instruction
halted  out  1  state == HALT
dbg_addr  in  3  debug register index
dbg_data  out  DATA_W  combinational read of committed rf[dbg_addr]
illegal_cnt  out  8  illegal-op count, saturates at 255
retire_cnt  out  CNT_W  writebacks completed, wraps

Behaviour:
- Reset (rst_n low, async): all rf entries 0; alu_a/alu_b/alu_op 0; ex_valid 0; state RUN; illegal_cnt 0; retire_cnt 0. An in-flight EX instruction is discarded (no writeback).
- Accept: an instruction is accepted on an edge where instr_valid && instr_ready. instr_ready = (state == RUN).
- Latency: instruction accepted at edge N drives alu_a/alu_b/alu_op/ex_valid from N to N+1. rf[rd] is written at edge N+1 with alu_result. retire_cnt increments at N+1.
- Back-to-back: one instruction per cycle sustained; no stalls.
- ALU ops 0-5: alu_a = R(rs1), alu_b = R(rs2), alu_op = op, writes rd.
- LI (op 6): alu_a = imm, alu_b = 0, alu_op = 0, writes rd, so the result returns through the ALU as imm.
- Illegal ops 7-14: EX loads ex_valid = 0 (NOP); illegal_cnt += 1 unless already 255.
- HALT (op 15): EX loads ex_valid = 0; state RUN -> HALT at the accepting edge.
- HALT state: any in-flight EX still writes back; resume returns to RUN at the next edge. resume in RUN is ignored.
- Register 0: reads as 0; writes to r0 are discarded and still count as retired. Forwarding is never applied for r0.
- Operand read R(x), highest priority first:
  - x == 0 -> 0
  - ex_valid && ex_rd == x -> alu_result (forward)
  - otherwise rf[x]
- Forwarding covers both rs1 and rs2 in the same cycle.
- dbg_data returns the pre-write value when a writeback to dbg_addr occurs in the same cycle.
- Width rules: all datapath arithmetic is DATA_W wide in the ALU; this block performs no arithmetic except the counters.

Decomposition:
- Package alu_pkg holds:
  - op enum: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLT=4, OP_XOR=5, OP_LI=6, OP_HALT=15
  - instruction field position constants
  - state enum {RUN, HALT}
  - the instruction struct typedef
- Sub-module alu_regfile: 8 x DATA_W registers, 2 combinational read ports plus a debug read port, 1 write port, r0 hardwired to zero, async active-low reset.

Test Plan:
- LI r1,0x05; LI r2,0x03; ADD r3,r1,r2 issued back-to-back -> cycle of ADD shows alu_a=5, alu_b=3 via forwarding (r2 from EX); dbg r3 = 0x08 after next edge; retire_cnt=3.
- SUB r4,r2,r1 then SLT r5,r2,r1 using r1=5, r2=3 -> r4=0xFE, r5=0x01. XOR r6,r1,r1 -> r6=0x00.
- LI r0,0xAA then ADD r7,r0,r0 -> alu_a=alu_b=0 (no forward), r7=0, dbg r0 = 0.
- Ops 7..14 issued 300 times -> illegal_cnt=255, no rf change, ex_valid low on each.
- LI r1,0x11 then HALT then instr_valid held high -> instr_ready low, halted=1; r1=0x11 still written; resume pulse -> ready high the next cycle.
- Assert rst_n low in the cycle after accepting LI r2,0x77 -> r2 stays 0, ex_valid=0, counters 0, state RUN.
